// File: rtl/core_sequencer_if.sv
// ----------------------------------------------------------------------------
// core_sequencer_if
//
// Purpose:
//   Groups the instruction-fetch and data-memory request/ready handshakes that
//   the core sequencer exchanges with the memory side of the datapath.
//
// Signals:
//   imem_req    sequencer -> memory  instruction fetch request
//   imem_ready  memory -> sequencer  instruction word available this cycle
//   dmem_req    sequencer -> memory  data access request
//   dmem_we     sequencer -> memory  data access is a write (store)
//   dmem_ready  memory -> sequencer  data access completes this cycle
//
// Modports:
//   master  the sequencer side (drives requests, samples readies)
//   slave   the memory side (samples requests, drives readies)
// ----------------------------------------------------------------------------
interface core_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// ----------------------------------------------------------------------------
// core_sequencer
//
// Purpose:
//   Multi-cycle control sequencer for an RV32I-style core.  Walks every
//   instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and issues
//   the datapath strobes and selects for each step.  A watchdog bounds every
//   memory wait; if memory never answers the sequencer parks in HALT with a
//   sticky timeout flag until the next reset.
//
// Parameters:
//   TIMEOUT_W      width of the memory-wait watchdog; a wait is abandoned
//                  after 2^TIMEOUT_W-1 cycles without a ready
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   opcode[6:0]    instruction[6:0] from the instruction register
//   branch_taken   ALU compare result, only looked at in EXEC
//   mem            memory handshake bundle (core_sequencer_if.master)
//   ir_we          load instruction register (one cycle, end of fetch)
//   pc_we          update program counter
//   rf_we          write register file
//   alu_src        ALU operand B: 0 register, 1 immediate
//   pc_sel[1:0]    next PC: 00 PC+4, 01 branch target, 10 JAL, 11 JALR
//   wb_sel[1:0]    writeback source: 00 ALU, 01 memory, 10 PC+4, 11 immediate
//   alu_op[1:0]    ALU control: 00 add, 01 branch compare, 10 funct decode
//   state[2:0]     current FSM state (FETCH=0 ... HALT=5)
//   retire         one-cycle pulse when an instruction completes
//   mem_timeout    sticky: a memory wait hit the watchdog limit
//   illegal_instr  sticky: an unrecognized opcode was trapped
//
// Build option:
//   CORE_SEQUENCER_TRAP_ILLEGAL_EN  when defined, an unrecognized opcode in
//   DECODE sets illegal_instr and halts.  When undefined (default) it simply
//   retires as a NOP from EXEC.
// ----------------------------------------------------------------------------
module core_sequencer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opcode,
    input  logic              branch_taken,
    core_sequencer_if.master  mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic              rf_we,
    output logic              alu_src,
    output logic [1:0]        pc_sel,
    output logic [1:0]        wb_sel,
    output logic [1:0]        alu_op,
    output logic [2:0]        state,
    output logic              retire,
    output logic              mem_timeout,
    output logic              illegal_instr
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_IALU,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE
    } instClass_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // The wait that starts with the counter at WD_LAST is the one that takes
    // the counter to all-ones, i.e. the terminal waiting cycle.
    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               r_state;
    instClass_t           r_class;
    logic [1:0]           r_wbSel;
    logic [1:0]           r_aluOp;
    logic                 r_aluSrc;
    logic [TIMEOUT_W-1:0] r_wdCount;
    logic                 r_memTimeout;
    logic                 r_illegal;

    instClass_t           w_decClass;
    logic [1:0]           w_decWbSel;
    logic [1:0]           w_decAluOp;
    logic                 w_decAluSrc;

    state_t               w_nextState;
    logic                 w_imemReq;
    logic                 w_dmemReq;
    logic                 w_dmemWe;
    logic                 w_irWe;
    logic                 w_pcWe;
    logic                 w_rfWe;
    logic                 w_retire;
    logic [1:0]           w_pcSel;
    logic                 w_waiting;
    logic                 w_timeoutHit;
    logic                 w_trapIllegal;
    logic                 w_enterWait;
    logic                 w_outEn;

    // Opcode decoder.  Only sampled into the instruction registers while in
    // DECODE, so the opcode input is free to change for the rest of the
    // instruction.  Anything not in the table decodes as CLS_NOP.
    always_comb begin
        w_decClass  = CLS_NOP;
        w_decWbSel  = WB_ALU;
        w_decAluOp  = ALU_ADD;
        w_decAluSrc = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                w_decClass  = CLS_RTYPE;
                w_decAluOp  = ALU_FUNCT;
            end
            OP_IALU: begin
                w_decClass  = CLS_IALU;
                w_decAluOp  = ALU_FUNCT;
                w_decAluSrc = 1'b1;
            end
            OP_LUI: begin
                w_decClass  = CLS_LUI;
                w_decWbSel  = WB_IMM;
                w_decAluSrc = 1'b1;
            end
            OP_AUIPC: begin
                w_decClass  = CLS_AUIPC;
                w_decAluSrc = 1'b1;
            end
            OP_JAL: begin
                w_decClass  = CLS_JAL;
                w_decWbSel  = WB_PC4;
                w_decAluSrc = 1'b1;
            end
            OP_JALR: begin
                w_decClass  = CLS_JALR;
                w_decWbSel  = WB_PC4;
                w_decAluSrc = 1'b1;
            end
            OP_BRANCH: begin
                w_decClass  = CLS_BRANCH;
                w_decAluOp  = ALU_BR;
            end
            OP_LOAD: begin
                w_decClass  = CLS_LOAD;
                w_decWbSel  = WB_MEM;
                w_decAluSrc = 1'b1;
            end
            OP_STORE: begin
                w_decClass  = CLS_STORE;
                w_decAluSrc = 1'b1;
            end
            default: begin
                w_decClass  = CLS_NOP;
            end
        endcase
    end

    // Next-state and strobe logic.  Requests are held for the whole time the
    // FSM sits in FETCH or MEM, so a request can only disappear once its ready
    // has been seen (or on reset/timeout).  Readies are only consulted in the
    // state that owns them.
    always_comb begin
        w_nextState   = r_state;
        w_imemReq     = 1'b0;
        w_dmemReq     = 1'b0;
        w_dmemWe      = 1'b0;
        w_irWe        = 1'b0;
        w_pcWe        = 1'b0;
        w_rfWe        = 1'b0;
        w_retire      = 1'b0;
        w_pcSel       = PC_PLUS4;
        w_waiting     = 1'b0;
        w_timeoutHit  = 1'b0;
        w_trapIllegal = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imemReq = 1'b1;
                if (mem.imem_ready) begin
                    w_irWe      = 1'b1;
                    w_nextState = ST_DECODE;
                end else begin
                    w_waiting = 1'b1;
                    if (r_wdCount == WD_LAST) begin
                        w_timeoutHit = 1'b1;
                        w_nextState  = ST_HALT;
                    end
                end
            end
            ST_DECODE: begin
`ifdef CORE_SEQUENCER_TRAP_ILLEGAL_EN
                if (w_decClass == CLS_NOP) begin
                    w_trapIllegal = 1'b1;
                    w_nextState   = ST_HALT;
                end else begin
                    w_nextState   = ST_EXEC;
                end
`else
                w_nextState = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_BRANCH: begin
                        w_pcWe      = 1'b1;
                        w_pcSel     = branch_taken ? PC_BRANCH : PC_PLUS4;
                        w_retire    = 1'b1;
                        w_nextState = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        w_nextState = ST_MEM;
                    end
                    CLS_NOP: begin
                        w_pcWe      = 1'b1;
                        w_retire    = 1'b1;
                        w_nextState = ST_FETCH;
                    end
                    default: begin
                        w_nextState = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                w_dmemReq = 1'b1;
                w_dmemWe  = (r_class == CLS_STORE);
                if (mem.dmem_ready) begin
                    if (r_class == CLS_STORE) begin
                        w_pcWe      = 1'b1;
                        w_retire    = 1'b1;
                        w_nextState = ST_FETCH;
                    end else begin
                        w_nextState = ST_WB;
                    end
                end else begin
                    w_waiting = 1'b1;
                    if (r_wdCount == WD_LAST) begin
                        w_timeoutHit = 1'b1;
                        w_nextState  = ST_HALT;
                    end
                end
            end
            ST_WB: begin
                w_rfWe      = 1'b1;
                w_pcWe      = 1'b1;
                w_retire    = 1'b1;
                w_nextState = ST_FETCH;
                if (r_class == CLS_JAL) begin
                    w_pcSel = PC_JAL;
                end else if (r_class == CLS_JALR) begin
                    w_pcSel = PC_JALR;
                end
            end
            ST_HALT: begin
                w_nextState = ST_HALT;
            end
            default: begin
                w_nextState = ST_FETCH;
            end
        endcase
    end

    // The watchdog restarts whenever the FSM moves into one of the two
    // waiting states, so each fetch and each data access gets a full budget.
    assign w_enterWait = ((w_nextState == ST_FETCH) || (w_nextState == ST_MEM))
                         && (w_nextState != r_state);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Per-instruction control captured in DECODE and held untouched until
    // the next DECODE, which keeps alu_op/alu_src/wb_sel stable across EXEC,
    // MEM and WB regardless of what the opcode input does meanwhile.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_class  <= CLS_NOP;
            r_wbSel  <= WB_ALU;
            r_aluOp  <= ALU_ADD;
            r_aluSrc <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_class  <= w_decClass;
            r_wbSel  <= w_decWbSel;
            r_aluOp  <= w_decAluOp;
            r_aluSrc <= w_decAluSrc;
        end
    end

    // Memory-wait watchdog.  Counts only cycles where a request is pending
    // without its ready; a ready in the terminal cycle wins over the timeout
    // because the FSM checks ready first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdCount <= '0;
        end else if (w_enterWait) begin
            r_wdCount <= '0;
        end else if (w_waiting) begin
            r_wdCount <= r_wdCount + WD_ONE;
        end
    end

    // Sticky error flags; only a reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_memTimeout <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_timeoutHit) begin
                r_memTimeout <= 1'b1;
            end
            if (w_trapIllegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Everything driven toward the datapath or memory is forced low while
    // reset is asserted (so requests vanish immediately) and while halted.
    assign w_outEn      = rst_n && (r_state != ST_HALT);

    assign mem.imem_req = w_outEn & w_imemReq;
    assign mem.dmem_req = w_outEn & w_dmemReq;
    assign mem.dmem_we  = w_outEn & w_dmemWe;
    assign ir_we        = w_outEn & w_irWe;
    assign pc_we        = w_outEn & w_pcWe;
    assign rf_we        = w_outEn & w_rfWe;
    assign retire       = w_outEn & w_retire;
    assign alu_src      = w_outEn & r_aluSrc;
    assign pc_sel       = w_outEn ? w_pcSel : PC_PLUS4;
    assign wb_sel       = w_outEn ? r_wbSel : WB_ALU;
    assign alu_op       = w_outEn ? r_aluOp : ALU_ADD;
    assign state        = r_state;
    assign mem_timeout  = r_memTimeout;
    assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_core_sequencer.sv
// ----------------------------------------------------------------------------
// tb_core_sequencer
//
// Purpose:
//   Self-checking bench for core_sequencer, built with TIMEOUT_W=4 so the
//   watchdog limit (15 wait cycles) is reachable quickly.  Each instruction's
//   expected state trace, retire latency, PC select and strobe counts come
//   from a per-class model of the instruction flow.
// ----------------------------------------------------------------------------
module tb_core_sequencer;

    localparam int TW = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       ir_we, pc_we, rf_we, alu_src;
    logic [1:0] pc_sel, wb_sel, alu_op;
    logic [2:0] state;
    logic       retire, mem_timeout, illegal_instr;

    int testsRun = 0;
    int testsFailed = 0;

    logic [6:0] opTable [10];

    core_sequencer_if memBus ();

    core_sequencer #(.TIMEOUT_W(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem           (memBus.master),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .rf_we         (rf_we),
        .alu_src       (alu_src),
        .pc_sel        (pc_sel),
        .wb_sel        (wb_sel),
        .alu_op        (alu_op),
        .state         (state),
        .retire        (retire),
        .mem_timeout   (mem_timeout),
        .illegal_instr (illegal_instr)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Instruction class: 0 unknown, 1 R, 2 I-ALU, 3 LUI, 4 AUIPC, 5 JAL,
    // 6 JALR, 7 branch, 8 load, 9 store.
    function automatic int classOf(input logic [6:0] op);
        case (op)
            OP_R:     return 1;
            OP_I:     return 2;
            OP_LUI:   return 3;
            OP_AUIPC: return 4;
            OP_JAL:   return 5;
            OP_JALR:  return 6;
            OP_BR:    return 7;
            OP_LD:    return 8;
            OP_ST:    return 9;
            default:  return 0;
        endcase
    endfunction

    // Runs one instruction with iw fetch wait cycles and dw data wait cycles
    // and checks everything it saw against the class model.
    task automatic run_instr(input logic [6:0] op, input logic taken,
                             input int iw, input int dw, input string tag);
        int         cls, expLen, iCnt, dCnt, k;
        int         rfCnt, pcWeCnt, irCnt, dWeCnt, unstable;
        logic [63:0] expTrace, gotTrace;
        logic [1:0] expSel, gotSel, heldOp;
        logic       heldSrc, isMem, doesWb, done, flagsBad;
        cls      = classOf(op);
        isMem    = (cls == 8) || (cls == 9);
        doesWb   = ((cls >= 1) && (cls <= 6)) || (cls == 8);
        expTrace = '0;
        expLen   = 0;
        for (int i = 0; i <= iw; i++) begin
            expTrace = {expTrace[60:0], 3'd0};
            expLen++;
        end
        expTrace = {expTrace[60:0], 3'd1};
        expTrace = {expTrace[60:0], 3'd2};
        expLen  += 2;
        if (isMem) begin
            for (int i = 0; i <= dw; i++) begin
                expTrace = {expTrace[60:0], 3'd3};
                expLen++;
            end
        end
        if (doesWb) begin
            expTrace = {expTrace[60:0], 3'd4};
            expLen++;
        end
        expSel = (cls == 7) ? (taken ? 2'b01 : 2'b00) :
                 (cls == 5) ? 2'b10 : (cls == 6) ? 2'b11 : 2'b00;

        gotTrace = '0; gotSel = 2'b00; heldOp = 2'b00; heldSrc = 1'b0;
        iCnt = 0; dCnt = 0; rfCnt = 0; pcWeCnt = 0; irCnt = 0; dWeCnt = 0;
        unstable = 0; done = 1'b0; flagsBad = 1'b0;
        for (k = 0; (k < expLen + 8) && !done; k++) begin
            @(posedge clk);
            #1;
            opcode       = (k <= iw + 1) ? op : 7'($urandom);
            branch_taken = (k == iw + 2) ? taken : 1'($urandom);
            memBus.imem_ready = memBus.imem_req ? (iCnt == iw) : 1'($urandom);
            memBus.dmem_ready = memBus.dmem_req ? (dCnt == dw) : 1'($urandom);
            #1;
            gotTrace = {gotTrace[60:0], state};
            if (memBus.imem_req) iCnt++;
            if (memBus.dmem_req) dCnt++;
            if (memBus.dmem_we) dWeCnt++;
            if (rf_we) rfCnt++;
            if (pc_we) pcWeCnt++;
            if (ir_we) irCnt++;
            if (mem_timeout || illegal_instr) flagsBad = 1'b1;
            if (k == iw + 2) begin
                heldOp  = alu_op;
                heldSrc = alu_src;
            end else if ((k > iw + 2) && ((alu_op !== heldOp) || (alu_src !== heldSrc))) begin
                unstable++;
            end
            if (retire) begin
                gotSel = pc_sel;
                done   = 1'b1;
            end
        end

        testsRun++;
        if (done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s retire: got %0b expected 1 within %0d cycles", tag, done, expLen + 8);
        end
        testsRun++;
        if (gotTrace !== expTrace) begin
            testsFailed++;
            $display("[TB] FAIL %s trace: got %h expected %h", tag, gotTrace, expTrace);
        end
        testsRun++;
        if (gotSel !== expSel) begin
            testsFailed++;
            $display("[TB] FAIL %s pc_sel: got %b expected %b", tag, gotSel, expSel);
        end
        testsRun++;
        if (rfCnt !== (doesWb ? 1 : 0)) begin
            testsFailed++;
            $display("[TB] FAIL %s rf_we_cycles: got %0d expected %0d", tag, rfCnt, doesWb ? 1 : 0);
        end
        testsRun++;
        if ((pcWeCnt !== 1) || (irCnt !== 1)) begin
            testsFailed++;
            $display("[TB] FAIL %s pc_we/ir_we cycles: got %0d/%0d expected 1/1", tag, pcWeCnt, irCnt);
        end
        testsRun++;
        if (dCnt !== (isMem ? dw + 1 : 0)) begin
            testsFailed++;
            $display("[TB] FAIL %s dmem_req_cycles: got %0d expected %0d", tag, dCnt, isMem ? dw + 1 : 0);
        end
        testsRun++;
        if (dWeCnt !== ((cls == 9) ? dw + 1 : 0)) begin
            testsFailed++;
            $display("[TB] FAIL %s dmem_we_cycles: got %0d expected %0d", tag, dWeCnt, (cls == 9) ? dw + 1 : 0);
        end
        testsRun++;
        if (unstable !== 0) begin
            testsFailed++;
            $display("[TB] FAIL %s alu_hold: got %0d changes expected 0", tag, unstable);
        end
        testsRun++;
        if (flagsBad !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s error_flags: got %0b expected 0", tag, flagsBad);
        end
    endtask

    // Synchronous reset for three edges, then release; checks the quiet
    // outputs during reset and that a fetch request starts right after.
    task automatic test_reset();
        logic [17:0] quiet;
        rst_n = 1'b0;
        memBus.imem_ready = 1'b0;
        memBus.dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        quiet = {ir_we, pc_we, rf_we, alu_src, pc_sel, wb_sel, alu_op, retire,
                 mem_timeout, illegal_instr, memBus.imem_req, memBus.dmem_req,
                 memBus.dmem_we, state};
        testsRun++;
        if (quiet !== 18'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %b expected all zero", quiet);
        end
        rst_n = 1'b1;
        #1;
        testsRun++;
        if ((memBus.imem_req !== 1'b1) || (state !== 3'd0)) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got imem_req=%b state=%0d expected 1/0", memBus.imem_req, state);
        end
    endtask

    task automatic test_add();
        run_instr(OP_R, 1'b0, 0, 0, "add_zero_wait");
    endtask

    task automatic test_load_wait();
        run_instr(OP_LD, 1'b0, 0, 3, "lw_wait3");
        run_instr(OP_ST, 1'b0, 1, 2, "sw_wait2");
    endtask

    task automatic test_branch();
        run_instr(OP_BR, 1'b1, 0, 0, "beq_taken");
        run_instr(OP_BR, 1'b0, 0, 0, "beq_not_taken");
        run_instr(OP_JAL, 1'b0, 0, 0, "jal");
        run_instr(OP_JALR, 1'b0, 0, 0, "jalr");
    endtask

    // Ready arriving in the last allowed wait cycle must still complete.
    task automatic test_watchdog_boundary();
        run_instr(OP_I, 1'b0, 14, 0, "fetch_ready_at_limit");
        run_instr(OP_LD, 1'b0, 0, 14, "load_ready_at_limit");
    endtask

    task automatic test_back_to_back();
        int n;
`ifdef CORE_SEQUENCER_TRAP_ILLEGAL_EN
        n = 9;
`else
        n = 10;
`endif
        for (int i = 0; i < 40; i++) begin
            run_instr(opTable[$urandom_range(n - 1, 0)], 1'($urandom),
                      $urandom_range(3, 0), $urandom_range(3, 0), "random");
        end
    endtask

    task automatic test_illegal();
`ifdef CORE_SEQUENCER_TRAP_ILLEGAL_EN
        int c;
        c = 0;
        while ((state !== 3'd5) && (c < 10)) begin
            @(posedge clk);
            #1;
            opcode = OP_BAD;
            memBus.imem_ready = memBus.imem_req;
            #1;
            c++;
        end
        testsRun++;
        if ((state !== 3'd5) || (illegal_instr !== 1'b1) || (memBus.imem_req !== 1'b0)) begin
            testsFailed++;
            $display("[TB] FAIL illegal_trap: got state=%0d illegal=%b imem_req=%b expected 5/1/0",
                     state, illegal_instr, memBus.imem_req);
        end
        test_reset();
`else
        run_instr(OP_BAD, 1'b0, 0, 0, "illegal_as_nop");
`endif
    endtask

    // Reset pulsed while a store waits in MEM: the request drops and the
    // store never retires.
    task automatic test_reset_mid_mem();
        int c;
        int retires;
        c = 0;
        retires = 0;
        while ((state !== 3'd3) && (c < 12)) begin
            @(posedge clk);
            #1;
            opcode = OP_ST;
            memBus.imem_ready = memBus.imem_req;
            memBus.dmem_ready = 1'b0;
            #1;
            if (retire) retires++;
            c++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        testsRun++;
        if ((memBus.dmem_req !== 1'b0) || (state !== 3'd0) || (retire !== 1'b0) || (retires !== 0)) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_mem: got dmem_req=%b state=%0d retires=%0d expected 0/0/0",
                     memBus.dmem_req, state, retires + retire);
        end
        memBus.imem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        testsRun++;
        if (memBus.imem_req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_mem_release: got imem_req=%b expected 1", memBus.imem_req);
        end
    endtask

    // Fetch never answered: HALT with sticky timeout after 15 wait cycles,
    // then nothing moves even if memory starts answering.
    task automatic test_timeout();
        int c;
        int bad;
        c = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            memBus.imem_ready = 1'b0;
            memBus.dmem_ready = 1'b0;
            #1;
            if (state === 3'd5) break;
            c++;
        end
        testsRun++;
        if ((c !== 15) || (mem_timeout !== 1'b1) || (state !== 3'd5)) begin
            testsFailed++;
            $display("[TB] FAIL fetch_timeout: got waits=%0d timeout=%b state=%0d expected 15/1/5",
                     c, mem_timeout, state);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            memBus.imem_ready = 1'b1;
            memBus.dmem_ready = 1'b1;
            #1;
            if ((state !== 3'd5) || memBus.imem_req || memBus.dmem_req || retire ||
                pc_we || ir_we || rf_we || (mem_timeout !== 1'b1)) bad++;
        end
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL halt_hold: got %0d bad cycles expected 0", bad);
        end
    endtask

    // Test sequence.
    initial begin
        memBus.imem_ready = 1'b0;
        memBus.dmem_ready = 1'b0;
        opTable[0] = OP_R;   opTable[1] = OP_I;     opTable[2] = OP_LUI;
        opTable[3] = OP_AUIPC; opTable[4] = OP_JAL; opTable[5] = OP_JALR;
        opTable[6] = OP_BR;  opTable[7] = OP_LD;    opTable[8] = OP_ST;
        opTable[9] = OP_BAD;

        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_watchdog_boundary();
        test_illegal();
        test_reset_mid_mem();
        run_instr(OP_AUIPC, 1'b0, 1, 0, "after_mid_reset");
        test_timeout();
        test_reset();
        run_instr(OP_LUI, 1'b0, 0, 0, "after_halt_reset");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 8, giving the width of the memory-wait watchdog counter.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port opcode  in  7  instruction[6:0] from the instruction register.
REQ-005 SHALL have port branch_taken  in  1  ALU compare result, valid in EXEC.
REQ-006 SHALL have ports imem_req out 1 / imem_ready in 1  instruction-fetch handshake.
REQ-007 SHALL have ports dmem_req out 1 / dmem_we out 1 / dmem_ready in 1  data-memory handshake.
REQ-008 SHALL have ports ir_we, pc_we, rf_we, alu_src  out  1 each  datapath strobes.
REQ-009 SHALL have ports pc_sel, wb_sel, alu_op  out  2 each  selects: pc_sel 00 PC+4, 01 branch target, 10 JAL target, 11 JALR target; wb_sel/alu_op use the existing Main Control encodings.
REQ-010 SHALL have ports state out 3, retire out 1, mem_timeout out 1, illegal_instr out 1.

Function
REQ-011 SHALL implement the FSM FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, with state output = current state.
REQ-012 FETCH SHALL hold imem_req=1 until imem_ready; on ready SHALL pulse ir_we for one cycle and go to DECODE.
REQ-013 DECODE SHALL take 1 cycle and register class, wb_sel, alu_op and alu_src from opcode; later opcode changes SHALL NOT affect the instruction.
REQ-014 EXEC for a branch (1100011) SHALL assert pc_we, with pc_sel=01 if branch_taken else 00, pulse retire, and go to FETCH.
REQ-015 EXEC SHALL go to MEM for load/store, and to WB for R-type, I-ALU, LUI, AUIPC, JAL and JALR.
REQ-016 MEM SHALL hold dmem_req=1 (dmem_we=1 for stores) until dmem_ready; on ready a store SHALL assert pc_we with pc_sel=00, pulse retire and go to FETCH, and a load SHALL go to WB.
REQ-017 WB SHALL assert rf_we, pc_we and retire for exactly one cycle, with pc_sel 10 for JAL, 11 for JALR, else 00, then go to FETCH.
REQ-018 Latency with zero-wait memory SHALL be: branch 3 cycles, store/ALU/LUI/AUIPC/JAL/JALR 4, load 5.
REQ-019 Once asserted, a request SHALL NOT be withdrawn before its ready.
REQ-020 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-021 The watchdog SHALL clear on entry to FETCH or MEM and count each waiting cycle; reaching 2^TIMEOUT_W-1 SHALL set sticky mem_timeout and go to HALT.
REQ-022 A ready arriving in the same cycle as terminal count SHALL complete normally, with no timeout.
REQ-023 HALT SHALL drive all strobes and requests to 0 and remain in HALT until reset.
REQ-024 alu_op and alu_src SHALL be held stable from EXEC through the end of the instruction.

Reset
REQ-025 On rst_n=0 at a clk edge: state=FETCH; watchdog=0; all strobes, requests, retire, mem_timeout and illegal_instr = 0; pc_sel, wb_sel, alu_op = 00.
REQ-026 Reset mid-transaction SHALL drop imem_req/dmem_req after that edge and discard the in-flight instruction with no retire.
REQ-027 Requests SHALL be 0 while rst_n=0; imem_req SHALL rise the first cycle after release.

Configuration
REQ-028 Macro CORE_SEQUENCER_TRAP_ILLEGAL_EN: when defined, an unrecognized opcode in DECODE SHALL set sticky illegal_instr and go to HALT.
REQ-029 Without the macro, an unrecognized opcode SHALL execute as a NOP: EXEC asserts pc_we with pc_sel=00 and retire, no rf_we/dmem_req, then FETCH; illegal_instr stays 0.

Verification
REQ-030 ADD (0110011), zero-wait: states 0,1,2,4 -> rf_we and retire high in cycle 4, pc_sel=00.
REQ-031 LW (0000011), dmem_ready delayed 3 cycles: dmem_req high 4 cycles, dmem_we=0, WB follows, retire in cycle 8.
REQ-032 BEQ with branch_taken=1: pc_we and retire in cycle 3, pc_sel=01, rf_we never high.
REQ-033 TIMEOUT_W=4, imem_ready held 0: mem_timeout=1 and state=5 after 15 wait cycles; imem_req=0 thereafter.
REQ-034 rst_n pulsed low during MEM of SW: dmem_req=0 next cycle, no retire, state=0, imem_req rises after release.
REQ-035 Opcode 0000000: with macro -> illegal_instr=1, state=5; without -> retire in cycle 3, pc_sel=00.
